// File: rtl/viterbi_ber_checker_if.sv
// ---------------------------------------------------------------------------
// viterbi_ber_checker_if
//   Bundles the control, stream and result signals of the BER scoreboard.
//   master : drives start/mode/latency and the tx/rx beat streams, reads results
//   slave  : the scoreboard itself
//   Signals: start_i, mode_i, latency_i[LAT_W], tx_valid_i, tx_bit_i[N_CH],
//            rx_valid_i, rx_bit_i[N_CH], good_o/bad_o[CNT_W], err_ch_o[N_CH],
//            busy_o, done_o, overflow_o, underflow_o
// ---------------------------------------------------------------------------
interface viterbi_ber_checker_if #(
   parameter int N_CH  = 1,
   parameter int LAT_W = 11,
   parameter int CNT_W = 32
);
   logic             start_i;
   logic             mode_i;
   logic [LAT_W-1:0] latency_i;
   logic             tx_valid_i;
   logic [N_CH-1:0]  tx_bit_i;
   logic             rx_valid_i;
   logic [N_CH-1:0]  rx_bit_i;
   logic [CNT_W-1:0] good_o;
   logic [CNT_W-1:0] bad_o;
   logic [N_CH-1:0]  err_ch_o;
   logic             busy_o;
   logic             done_o;
   logic             overflow_o;
   logic             underflow_o;

   modport master (
      output start_i, mode_i, latency_i, tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i,
      input  good_o, bad_o, err_ch_o, busy_o, done_o, overflow_o, underflow_o
   );

   modport slave (
      input  start_i, mode_i, latency_i, tx_valid_i, tx_bit_i, rx_valid_i, rx_bit_i,
      output good_o, bad_o, err_ch_o, busy_o, done_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/viterbi_ber_checker.sv
// ---------------------------------------------------------------------------
// viterbi_ber_checker
//   Bit-error scoreboard for a conv-encode / channel / Viterbi-decode chain.
//   Encoder input beats are kept in a circular history; after discarding the
//   decoder's flush beats, every decoded beat is compared with its source beat.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - viterbi_ber_checker_if.slave (control, tx/rx streams, results)
// ---------------------------------------------------------------------------
module viterbi_ber_checker #(
   parameter int N_CH  = 1,
   parameter int DEPTH = 2048,
   parameter int LAT_W = 11,
   parameter int WIN   = 256,
   parameter int CNT_W = 32
) (
   input logic                   clk,
   input logic                   rst,
   viterbi_ber_checker_if.slave  bus
);
   localparam int AW   = $clog2(DEPTH);
   localparam int OW   = AW + 1;
   localparam int WC_W = $clog2(WIN + 1);
   localparam logic [OW-1:0]   OCC_FULL = OW'(DEPTH);
   localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN - 1);

   typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;

   state_t           state_q;
   logic [LAT_W-1:0] skip_cnt_q;
   logic [WC_W-1:0]  win_cnt_q;
   logic             mode_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [OW-1:0]    occ_q;
   logic [OW-1:0]    occ_d;
   logic [CNT_W-1:0] good_q;
   logic [CNT_W-1:0] bad_q;
   logic [N_CH-1:0]  err_ch_q;
   logic             done_q;
   logic             overflow_q;
   logic             underflow_q;

   logic [N_CH-1:0]  hist [DEPTH];

   logic             push_req, pop_req, empty, full;
   logic             do_push, do_pop, underrun;
   logic [N_CH-1:0]  ref_bits, mismatch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // start_i overrides any stream activity in the same cycle.
   assign push_req = ((state_q == SKIP) || (state_q == CHECK)) && bus.tx_valid_i && !bus.start_i;
   assign pop_req  = (state_q == CHECK) && bus.rx_valid_i && !bus.start_i;
   assign empty    = (occ_q == '0);
   assign full     = (occ_q == OCC_FULL);
   // A simultaneous pop frees the slot, so a push at full still proceeds.
   assign do_push  = push_req && (!full || pop_req);
   // A simultaneous push at empty supplies the beat being compared.
   assign do_pop   = pop_req && (!empty || push_req);
   assign underrun = pop_req && !do_pop;
   // At empty the only candidate is the beat arriving this cycle (bypass).
   assign ref_bits = empty ? bus.tx_bit_i : hist[rd_ptr_q];
   assign mismatch = bus.rx_bit_i ^ ref_bits;

   always_comb begin
      occ_d = occ_q;
      if (do_push && !do_pop)
         occ_d = occ_q + OW'(1);
      else if (do_pop && !do_push)
         occ_d = occ_q - OW'(1);
   end

   // History storage carries data only; pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (do_push)
         hist[wr_ptr_q] <= bus.tx_bit_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         skip_cnt_q  <= '0;
         win_cnt_q   <= '0;
         mode_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         err_ch_q    <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.start_i) begin
         state_q     <= (bus.latency_i != '0) ? SKIP : CHECK;
         skip_cnt_q  <= bus.latency_i;
         win_cnt_q   <= '0;
         mode_q      <= bus.mode_i;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         err_ch_q    <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         if (do_push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (push_req && !do_push)
            overflow_q <= 1'b1;
         if (do_pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);

         if (pop_req) begin
            if (underrun) begin
               bad_q       <= sat_inc(bad_q);
               underflow_q <= 1'b1;
            end else if (mismatch == '0) begin
               good_q <= sat_inc(good_q);
            end else begin
               bad_q    <= sat_inc(bad_q);
               err_ch_q <= err_ch_q | mismatch;
            end
            // Underrun beats still count toward the window.
            if (!mode_q) begin
               win_cnt_q <= win_cnt_q + WC_W'(1);
               if (win_cnt_q == WIN_LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
         end

         if ((state_q == SKIP) && bus.rx_valid_i) begin
            skip_cnt_q <= skip_cnt_q - LAT_W'(1);
            if (skip_cnt_q == LAT_W'(1))
               state_q <= CHECK;
         end
      end
   end

   assign bus.good_o      = good_q;
   assign bus.bad_o       = bad_q;
   assign bus.err_ch_o    = err_ch_q;
   assign bus.busy_o      = (state_q == SKIP) || (state_q == CHECK);
   assign bus.done_o      = done_q;
   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// ---------------------------------------------------------------------------
// tb_viterbi_ber_checker
//   Directed and randomized stimulus for viterbi_ber_checker (N_CH=2,
//   DEPTH=64, WIN=256), checked every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_viterbi_ber_checker;
   localparam int N_CH  = 2;
   localparam int DEPTH = 64;
   localparam int LAT_W = 11;
   localparam int WIN   = 256;
   localparam int CNT_W = 32;
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   viterbi_ber_checker_if #(.N_CH(N_CH), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

   viterbi_ber_checker #(
      .N_CH(N_CH), .DEPTH(DEPTH), .LAT_W(LAT_W), .WIN(WIN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [N_CH-1:0] m_q[$];
   longint          m_good, m_bad;
   logic [N_CH-1:0] m_err;
   bit              m_run, m_done, m_ovf, m_unf, m_mode;
   int              m_skip, m_cmp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_good = 0; m_bad = 0; m_err = '0;
      m_run = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_mode = 0;
      m_skip = 0; m_cmp = 0;
   endtask

   task automatic bump(inout longint c);
      if (c < CNT_MAX) c++;
   endtask

   task automatic model_step(input logic st, input logic md, input int lat,
                             input logic tv, input logic [N_CH-1:0] tb,
                             input logic rv, input logic [N_CH-1:0] rb);
      bit in_chk, pop;
      logic [N_CH-1:0] r, d;
      if (st) begin
         model_reset();
         m_skip = lat; m_mode = md; m_run = 1;
         return;
      end
      if (!m_run) return;
      in_chk = (m_skip == 0);
      pop    = rv && in_chk;
      if (tv) begin
         if (m_q.size() == DEPTH && !pop) m_ovf = 1;
         else m_q.push_back(tb);
      end
      if (pop) begin
         if (m_q.size() == 0) begin
            bump(m_bad); m_unf = 1;
         end else begin
            r = m_q.pop_front();
            d = rb ^ r;
            if (d == '0) bump(m_good);
            else begin bump(m_bad); m_err |= d; end
         end
         m_cmp++;
         if (!m_mode && m_cmp == WIN) begin m_run = 0; m_done = 1; end
      end
      if (rv && !in_chk) m_skip--;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".good"},  64'(bus.good_o),      64'(m_good));
      chk({tag, ".bad"},   64'(bus.bad_o),       64'(m_bad));
      chk({tag, ".err"},   64'(bus.err_ch_o),    64'(m_err));
      chk({tag, ".busy"},  64'(bus.busy_o),      64'(m_run));
      chk({tag, ".done"},  64'(bus.done_o),      64'(m_done));
      chk({tag, ".ovf"},   64'(bus.overflow_o),  64'(m_ovf));
      chk({tag, ".unf"},   64'(bus.underflow_o), 64'(m_unf));
   endtask

   task automatic cyc(input string tag, input logic st, input logic md, input int lat,
                      input logic tv, input logic [N_CH-1:0] tb,
                      input logic rv, input logic [N_CH-1:0] rb);
      bus.start_i    = st;
      bus.mode_i     = md;
      bus.latency_i  = LAT_W'(lat);
      bus.tx_valid_i = tv;
      bus.tx_bit_i   = tb;
      bus.rx_valid_i = rv;
      bus.rx_bit_i   = rb;
      model_step(st, md, lat, tv, tb, rv, rb);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, '0, 0, '0);
   endtask

   // Source stream with rx trailing tx by 'delay' cycles, preceded by 'junk'
   // flush beats; compare index flip_idx gets flip_mask applied.
   task automatic stream(input string tag, input bit do_start, input logic md,
                         input int lat, input int junk, input int n_beats,
                         input int delay, input int flip_idx, input logic [N_CH-1:0] flip_mask);
      logic [N_CH-1:0] sent[$];
      int k, c, j;
      logic tv, rv;
      logic [N_CH-1:0] tb, rb;
      if (do_start) cyc({tag, ".start"}, 1, md, lat, 0, '0, 0, '0);
      k = 0; j = junk; c = 0;
      while (k < n_beats && c < 4000) begin
         tv = (sent.size() < n_beats) && ($urandom_range(0, 3) != 0);
         tb = N_CH'($urandom);
         rv = 0; rb = '0;
         if (j > 0) begin
            rv = 1; rb = N_CH'($urandom); j--;
         end else if (c >= delay && k < sent.size()) begin
            rv = 1; rb = sent[k] ^ ((k == flip_idx) ? flip_mask : '0); k++;
         end
         if (tv) sent.push_back(tb);
         cyc(tag, 0, 0, 0, tv, tb, rv, rb);
         c++;
      end
      chk({tag, ".beats_delivered"}, 64'(k), 64'(n_beats));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N_CH-1:0] first;
      logic [N_CH-1:0] tb, rb;
      logic tv, rv;
      int lat;
      logic md;

      bus.start_i = 0; bus.mode_i = 0; bus.latency_i = '0;
      bus.tx_valid_i = 0; bus.tx_bit_i = '0; bus.rx_valid_i = 0; bus.rx_bit_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.good", 64'(bus.good_o), 64'd0);
      chk("reset.bad",  64'(bus.bad_o),  64'd0);
      chk("reset.busy", 64'(bus.busy_o), 64'd0);
      check_all("reset");
      rst = 0;
      idle("idle", 2);

      // Single window, all beats matching
      stream("win_clean", 1, 0, 3, 3, WIN, 40, -1, '0);
      idle("win_clean.tail", 2);
      chk("win_clean.good", 64'(bus.good_o), 64'd256);
      chk("win_clean.bad",  64'(bus.bad_o),  64'd0);
      chk("win_clean.done", 64'(bus.done_o), 64'd1);
      chk("win_clean.busy", 64'(bus.busy_o), 64'd0);

      // Lane 1 flipped on compare index 10
      stream("win_flip", 1, 0, 3, 3, WIN, 40, 10, 2'b10);
      idle("win_flip.tail", 2);
      chk("win_flip.good", 64'(bus.good_o),   64'd255);
      chk("win_flip.bad",  64'(bus.bad_o),    64'd1);
      chk("win_flip.err",  64'(bus.err_ch_o), 64'(2'b10));
      chk("win_flip.done", 64'(bus.done_o),   64'd1);

      // History overflow: DEPTH+1 pushes with no rx
      cyc("ovf.start", 1, 0, 0, 0, '0, 0, '0);
      first = N_CH'($urandom);
      cyc("ovf.push0", 0, 0, 0, 1, first, 0, '0);
      for (int i = 1; i < DEPTH; i++) cyc("ovf.push", 0, 0, 0, 1, N_CH'($urandom), 0, '0);
      chk("ovf.full_no_flag", 64'(bus.overflow_o), 64'd0);
      cyc("ovf.drop", 0, 0, 0, 1, N_CH'($urandom), 0, '0);
      chk("ovf.flag", 64'(bus.overflow_o), 64'd1);
      cyc("ovf.cmp0", 0, 0, 0, 0, '0, 1, first);
      chk("ovf.cmp0_good", 64'(bus.good_o), 64'd1);
      chk("ovf.cmp0_bad",  64'(bus.bad_o),  64'd0);

      // Underflow, then bypass compare at empty
      cyc("unf.start", 1, 0, 0, 0, '0, 0, '0);
      cyc("unf.pop", 0, 0, 0, 0, '0, 1, 2'b01);
      chk("unf.flag", 64'(bus.underflow_o), 64'd1);
      chk("unf.bad",  64'(bus.bad_o),       64'd1);
      cyc("unf.push", 0, 0, 0, 1, 2'b11, 0, '0);
      cyc("unf.cmp0", 0, 0, 0, 0, '0, 1, 2'b11);
      chk("unf.rdptr_held_good", 64'(bus.good_o), 64'd1);
      cyc("unf.bypass", 0, 0, 0, 1, 2'b01, 1, 2'b01);
      chk("unf.bypass_good", 64'(bus.good_o), 64'd2);
      chk("unf.bypass_bad",  64'(bus.bad_o),  64'd1);

      // Continuous mode, restart after 100 compares
      stream("cont", 1, 1, 2, 2, 100, 10, 50, 2'b01);
      chk("cont.good", 64'(bus.good_o),   64'd99);
      chk("cont.err",  64'(bus.err_ch_o), 64'(2'b01));
      chk("cont.done", 64'(bus.done_o),   64'd0);
      cyc("cont.restart", 1, 1, 2, 1, 2'b11, 1, 2'b00);
      chk("cont.rs_good", 64'(bus.good_o),   64'd0);
      chk("cont.rs_bad",  64'(bus.bad_o),    64'd0);
      chk("cont.rs_err",  64'(bus.err_ch_o), 64'd0);
      chk("cont.rs_busy", 64'(bus.busy_o),   64'd1);
      cyc("cont.skip1", 0, 0, 0, 0, '0, 1, 2'b10);
      chk("cont.skip_bad", 64'(bus.bad_o),       64'd0);
      chk("cont.skip_unf", 64'(bus.underflow_o), 64'd0);
      stream("cont2", 0, 1, 2, 1, 200, 10, -1, '0);
      chk("cont2.good", 64'(bus.good_o), 64'd200);
      chk("cont2.busy", 64'(bus.busy_o), 64'd1);

      // Asynchronous reset mid-CHECK
      stream("rstmid", 1, 1, 0, 0, 50, 5, -1, '0);
      chk("rstmid.good50", 64'(bus.good_o), 64'd50);
      bus.tx_valid_i = 1; bus.rx_valid_i = 1;
      rst = 1;
      model_reset();
      #2;
      check_all("rstmid.async");
      chk("rstmid.async_good", 64'(bus.good_o), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < 3; i++) cyc("rstmid.norun", 0, 0, 0, 1, 2'b01, 1, 2'b01);
      chk("rstmid.norun_good", 64'(bus.good_o), 64'd0);
      chk("rstmid.norun_busy", 64'(bus.busy_o), 64'd0);

      // Randomized runs against the model
      for (int r = 0; r < 4; r++) begin
         lat = $urandom_range(0, 4);
         md  = 1'($urandom);
         cyc("rand.start", 1, md, lat, 0, '0, 0, '0);
         for (int i = 0; i < 150; i++) begin
            tv = ($urandom_range(0, 2) != 0);
            tb = N_CH'($urandom);
            rv = ($urandom_range(0, 2) != 0);
            if (m_q.size() > 0 && m_skip == 0 && $urandom_range(0, 3) != 0) rb = m_q[0];
            else rb = N_CH'($urandom);
            cyc("rand", 0, 0, 0, tv, tb, rv, rb);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
